// File: rtl/lb_divergence_monitor_if.sv
// Arm pulse plus the two load-buffer table copies compared by lb_divergence_monitor.
// The stimulus side drives through master; the monitor observes through slave.
interface lb_divergence_monitor_if;
    logic        arm;
    logic        lb_valid1;
    logic [31:0] lb_addr1;
    logic [31:0] lb_data1;
    logic        lb_valid2;
    logic [31:0] lb_addr2;
    logic [31:0] lb_data2;

    modport master (
        output arm,
        output lb_valid1,
        output lb_addr1,
        output lb_data1,
        output lb_valid2,
        output lb_addr2,
        output lb_data2
    );

    modport slave (
        input arm,
        input lb_valid1,
        input lb_addr1,
        input lb_data1,
        input lb_valid2,
        input lb_addr2,
        input lb_data2
    );
endinterface

// File: rtl/lb_divergence_monitor.sv
// Watches two load-buffer table copies for a fixed window after arm and reports divergence.
// Optional macro LB_DATA_CHECK_EN also flags equal-address entries whose data differ.
module lb_divergence_monitor #(
    parameter int unsigned WINDOW = 14,
    parameter int unsigned CYC_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    lb_divergence_monitor_if.slave   lb,
    output logic [1:0]               state,
    output logic                     sticky_diverge,
    output logic [CYC_W-1:0]         first_div_cycle,
    output logic [7:0]               div_count,
    output logic                     verdict_valid,
    output logic                     verdict_pass
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StObserve  = 2'd1,
        StDiverged = 2'd2,
        StDone     = 2'd3
    } state_e;

    localparam logic [CYC_W-1:0] LastCyc = CYC_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             sticky_q, sticky_d;
    logic [CYC_W-1:0] first_q, first_d;
    logic [7:0]       count_q, count_d;
    logic             vvalid_q, vvalid_d;
    logic             vpass_q, vpass_d;

    logic both_valid;
    logic mismatch;

    assign both_valid = lb.lb_valid1 & lb.lb_valid2;

`ifdef LB_DATA_CHECK_EN
    assign mismatch = (lb.lb_valid1 ^ lb.lb_valid2)
                    | (both_valid & (lb.lb_addr1 != lb.lb_addr2))
                    | (both_valid & (lb.lb_addr1 == lb.lb_addr2) & (lb.lb_data1 != lb.lb_data2));
`else
    logic unused_data;
    assign unused_data = ^{lb.lb_data1, lb.lb_data2};
    assign mismatch = (lb.lb_valid1 ^ lb.lb_valid2)
                    | (both_valid & (lb.lb_addr1 != lb.lb_addr2));
`endif

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        sticky_d = sticky_q;
        first_d  = first_q;
        count_d  = count_q;
        vvalid_d = 1'b0;
        vpass_d  = vpass_q;

        unique case (state_q)
            StIdle, StDone: begin
                // Arm starts a fresh window; in DONE it also discards the held results.
                if (lb.arm) begin
                    state_d  = StObserve;
                    cyc_d    = '0;
                    sticky_d = 1'b0;
                    first_d  = '0;
                    count_d  = '0;
                    vpass_d  = 1'b0;
                end
            end
            StObserve, StDiverged: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (mismatch) begin
                    sticky_d = 1'b1;
                    state_d  = StDiverged;
                    if (state_q == StObserve) begin
                        first_d = cyc_q;
                        count_d = 8'd1;
                    end else if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
                // The closing cycle's own mismatch still counts against the verdict.
                if (cyc_q == LastCyc) begin
                    state_d  = StDone;
                    vvalid_d = 1'b1;
                    vpass_d  = ~(sticky_q | mismatch);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            sticky_q <= 1'b0;
            first_q  <= '0;
            count_q  <= '0;
            vvalid_q <= 1'b0;
            vpass_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            sticky_q <= sticky_d;
            first_q  <= first_d;
            count_q  <= count_d;
            vvalid_q <= vvalid_d;
            vpass_q  <= vpass_d;
        end
    end

    assign state           = state_q;
    assign sticky_diverge  = sticky_q;
    assign first_div_cycle = first_q;
    assign div_count       = count_q;
    assign verdict_valid   = vvalid_q;
    assign verdict_pass    = vpass_q;

endmodule
